// File: rtl/matrix_link_pkg.sv
// Shared types and constants for the HPS<->FPGA matrix transfer controller
// and the matrix coprocessor it feeds.
package matrix_link_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DIM     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  // Opcodes understood by the coprocessor; passed through untouched here.
  localparam int unsigned OPC_ADD = 0;
  localparam int unsigned OPC_SUB = 1;
  localparam int unsigned OPC_MUL = 2;

endpackage

// File: rtl/matrix_link_ctrl_hs_sync.sv
// Two-flop synchroniser for an asynchronous control line, plus a third
// flop for rise/fall detection of the synchronised level.
module hs_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  // NOTE: non-blocking assignments make each flop take the old value of its
  // neighbour, which is what turns three statements into a shift chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/matrix_link_ctrl.sv
// Transfer controller between the HPS PIO bridge and the matrix coprocessor:
// loads A/B by handshake, starts the job, waits with timeout, streams result.
module matrix_link_ctrl
  import matrix_link_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int MAX_DIM = 5,
  parameter  int OPC_W   = 3,
  parameter  int TIMEOUT = 1024,
  localparam int DIM_W   = $clog2(MAX_DIM + 1),
  localparam int N       = MAX_DIM * MAX_DIM
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hps_req,
  input  logic                hps_start,
  input  logic                hps_abort,
  input  logic [OPC_W-1:0]    hps_opcode,
  input  logic [DIM_W-1:0]    hps_dim,
  input  logic [DATA_W-1:0]   hps_a,
  input  logic [DATA_W-1:0]   hps_b,
  output logic                fpga_ack,
  output logic [DATA_W-1:0]   fpga_rd,
  output logic                busy,
  output logic                error,
  output logic [1:0]          err_code,
  output logic                cp_start,
  output logic [OPC_W-1:0]    cp_opcode,
  output logic [DIM_W-1:0]    cp_dim,
  output logic [N*DATA_W-1:0] cp_a,
  output logic [N*DATA_W-1:0] cp_b,
  input  logic                cp_done,
  input  logic                cp_ovf,
  input  logic [N*DATA_W-1:0] cp_result
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  logic [DIM_W-1:0]   row, col, next_row, next_col;
  logic               last_row, last_col;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]  a_buf [N];
  logic [DATA_W-1:0]  b_buf [N];
  logic [DATA_W-1:0]  r_buf [N];

  logic req_level, req_rise, req_fall;
  logic abort_level, abort_rise, abort_fall;
  logic unused_sync;

  hs_sync u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hps_req),
    .level (req_level),
    .rise  (req_rise),
    .fall  (req_fall)
  );

  hs_sync u_abort_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hps_abort),
    .level (abort_level),
    .rise  (abort_rise),
    .fall  (abort_fall)
  );

  assign unused_sync = ^{req_level, abort_rise, abort_fall};

  // Row-major walk over the dim x dim corner of the MAX_DIM x MAX_DIM buffer.
  assign idx      = IDX_W'(int'(row) * MAX_DIM + int'(col));
  assign last_col = (col == cp_dim - DIM_W'(1));
  assign last_row = (row == cp_dim - DIM_W'(1));

  // NOTE: default assignment first, so no path through this block leaves
  // next_row unassigned and no latch is inferred.
  always_comb begin
    next_row = row;
    next_col = last_col ? '0 : col + DIM_W'(1);
    if (last_col) next_row = last_row ? '0 : row + DIM_W'(1);
  end

  assign busy = (state != S_IDLE);

  // NOTE: the operand buffers drive cp_a/cp_b directly, so they take the
  // async reset like any other output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      fpga_ack  <= 1'b0;
      fpga_rd   <= '0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
      cp_start  <= 1'b0;
      cp_opcode <= '0;
      cp_dim    <= '0;
      row       <= '0;
      col       <= '0;
      wait_cnt  <= '0;
      for (int k = 0; k < N; k++) begin
        a_buf[k] <= '0;
        b_buf[k] <= '0;
        r_buf[k] <= '0;
      end
    end else begin
      cp_start <= 1'b0;
      if (abort_level) begin
        state    <= S_IDLE;
        fpga_ack <= 1'b0;
        row      <= '0;
        col      <= '0;
        wait_cnt <= '0;
        error    <= 1'b0;
        err_code <= ERR_NONE;
      end else begin
        case (state)
          S_IDLE: begin
            if (hps_start) begin
              cp_opcode <= hps_opcode;
              cp_dim    <= hps_dim;
              if (hps_dim == '0 || hps_dim > DIM_W'(MAX_DIM)) begin
                error    <= 1'b1;
                err_code <= ERR_DIM;
              end else begin
                for (int k = 0; k < N; k++) begin
                  a_buf[k] <= '0;
                  b_buf[k] <= '0;
                end
                row      <= '0;
                col      <= '0;
                error    <= 1'b0;
                err_code <= ERR_NONE;
                state    <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (req_rise && !fpga_ack) begin
              a_buf[idx] <= hps_a;
              b_buf[idx] <= hps_b;
              fpga_ack   <= 1'b1;
            end else if (req_fall && fpga_ack) begin
              fpga_ack <= 1'b0;
              row      <= next_row;
              col      <= next_col;
              if (last_row && last_col) state <= S_START;
            end
          end
          S_START: begin
            cp_start <= 1'b1;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (cp_done) begin
              for (int k = 0; k < N; k++) r_buf[k] <= cp_result[k*DATA_W +: DATA_W];
              if (cp_ovf) begin
                error    <= 1'b1;
                err_code <= ERR_OVF;
              end
              state <= S_UNLOAD;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
              error    <= 1'b1;
              err_code <= ERR_TIMEOUT;
              state    <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          S_UNLOAD: begin
            if (req_rise && !fpga_ack) begin
              fpga_rd  <= r_buf[idx];
              fpga_ack <= 1'b1;
            end else if (req_fall && fpga_ack) begin
              fpga_ack <= 1'b0;
              row      <= next_row;
              col      <= next_col;
              if (last_row && last_col) state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign cp_a[k*DATA_W +: DATA_W] = a_buf[k];
    assign cp_b[k*DATA_W +: DATA_W] = b_buf[k];
  end

endmodule
